// File: rtl/amp_gain_loader.sv
// amp_gain_loader: SPI loader for a dual-channel programmable gain amplifier.
// A start request latches {gain_b, gain_a} (channel B MSB first) and shifts it out
// as one CS-framed SPI mode-0 word. SCK is a registered output, so no clock is gated.
// Optional build macro AMP_READBACK_EN: captures MISO (the amp's echo of the previous
// word) and presents it on readback when done pulses. Without the macro, readback is tied to 0.
module amp_gain_loader #(
    parameter int GAIN_W  = 4,
    parameter int CLK_DIV = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [GAIN_W-1:0]     gain_a,
    input  logic [GAIN_W-1:0]     gain_b,
    input  logic                  shdn_req,
    input  logic                  spi_miso,
    output logic                  spi_mosi,
    output logic                  spi_sck,
    output logic                  amp_cs,
    output logic                  amp_shdn,
    output logic                  busy,
    output logic                  done,
    output logic [2*GAIN_W-1:0]   readback
);

    localparam int NBITS = 2 * GAIN_W;
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(NBITS + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [BIT_W-1:0]   bits_r, bits_s;
    logic [NBITS-1:0]   shift_r, shift_s;
    logic               sck_r, sck_s;
    logic               mosi_r, mosi_s;
    logic               cs_r, cs_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic               shdn_r;
    logic               tick_s;
    logic               rise_s;
    logic               load_rb_s;

    // A tick is the last system clock of one SCK half-period.
    assign tick_s = (cnt_r == CNT_W'(CLK_DIV - 1));

    // Next-state and next-output decode; every frame is SETUP, 2*NBITS SCK half-periods, HOLD.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        bits_s    = bits_r;
        shift_s   = shift_r;
        sck_s     = sck_r;
        mosi_s    = mosi_r;
        cs_s      = cs_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        rise_s    = 1'b0;
        load_rb_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_s  = '0;
                sck_s  = 1'b0;
                cs_s   = 1'b1;
                mosi_s = 1'b0;
                busy_s = 1'b0;
                if (start) begin
                    shift_s = {gain_b, gain_a};
                    mosi_s  = gain_b[GAIN_W-1];
                    cs_s    = 1'b0;
                    busy_s  = 1'b1;
                    bits_s  = '0;
                    state_s = ST_SETUP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (tick_s) begin
                    // First rising SCK edge closes the setup half-period.
                    cnt_s   = '0;
                    sck_s   = 1'b1;
                    rise_s  = 1'b1;
                    state_s = ST_SHIFT;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_SHIFT: begin
                if (tick_s) begin
                    cnt_s = '0;
                    if (sck_r) begin
                        // Falling edge: present the next bit (zero after the last).
                        sck_s   = 1'b0;
                        shift_s = {shift_r[NBITS-2:0], 1'b0};
                        mosi_s  = shift_r[NBITS-2];
                        bits_s  = bits_r + BIT_W'(1);
                    end else if (bits_r == BIT_W'(NBITS)) begin
                        // Low half after the final falling edge is done.
                        mosi_s  = 1'b0;
                        state_s = ST_HOLD;
                    end else begin
                        sck_s  = 1'b1;
                        rise_s = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                mosi_s = 1'b0;
                sck_s  = 1'b0;
                if (tick_s) begin
                    cnt_s     = '0;
                    cs_s      = 1'b1;
                    busy_s    = 1'b0;
                    done_s    = 1'b1;
                    load_rb_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                cnt_s   = '0;
                sck_s   = 1'b0;
                cs_s    = 1'b1;
                mosi_s  = 1'b0;
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered SPI/handshake outputs; reset abandons any frame in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            bits_r  <= '0;
            shift_r <= '0;
            sck_r   <= 1'b0;
            mosi_r  <= 1'b0;
            cs_r    <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            bits_r  <= bits_s;
            shift_r <= shift_s;
            sck_r   <= sck_s;
            mosi_r  <= mosi_s;
            cs_r    <= cs_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Shutdown is a plain one-cycle copy of the request, unrelated to the frame FSM.
    always_ff @(posedge clock) begin
        if (reset) begin
            shdn_r <= 1'b0;
        end else begin
            shdn_r <= shdn_req;
        end
    end

    assign spi_mosi = mosi_r;
    assign spi_sck  = sck_r;
    assign amp_cs   = cs_r;
    assign amp_shdn = shdn_r;
    assign busy     = busy_r;
    assign done     = done_r;

`ifdef AMP_READBACK_EN
    logic [NBITS-1:0] cap_r;
    logic [NBITS-1:0] readback_r;

    // MISO is sampled on the same clock edge that raises SCK, then published at done.
    always_ff @(posedge clock) begin
        if (reset) begin
            cap_r      <= '0;
            readback_r <= '0;
        end else begin
            if (rise_s) begin
                cap_r <= {cap_r[NBITS-2:0], spi_miso};
            end else begin
                cap_r <= cap_r;
            end
            if (load_rb_s) begin
                readback_r <= cap_r;
            end else begin
                readback_r <= readback_r;
            end
        end
    end

    assign readback = readback_r;
`else
    logic unused_rb_s;

    // Without readback the echo path and its strobes are intentionally left unconnected.
    assign unused_rb_s = ^{spi_miso, rise_s, load_rb_s};
    assign readback    = '0;
`endif

endmodule
